out_port_uart_tx: RTL

- Output-port peripheral that sits directly downstream of the CPU datapath bus.
- Captures the 32-bit bus value whenever the control unit asserts the out-port load strobe, and holds the last value for display.
- Queues each captured word in a small FIFO and serialises it as four 8N1 UART frames, least-significant byte first, so the program's OUT results stream off-chip without stalling the CPU.

---
 rtl/out_port_uart_tx.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/out_port_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : out_port_uart_tx
// Description : CPU output port. Latches the bus word on each load strobe,
//               queues it in a small FIFO and streams it off-chip as four
//               8N1 UART frames, least-significant byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module out_port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             Out_Portin,
  input  logic [31:0]      Busout,
  input  logic             ovf_clr,
  output logic [31:0]      port_value,
  output logic             tx,
  output logic             busy,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] c_baud_one  = BAUD_W'(1);
  localparam logic [CNT_W-1:0]  c_cnt_full  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  c_ptr_one   = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      port_value_q, port_value_d;
  logic             overflow_q, overflow_d;

  // Transmitter state
  state_t           state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      shift_q, shift_d;
  logic             tx_q, tx_d;

  // Handshake wires between FIFO and transmitter
  logic w_empty;
  logic w_full;
  logic w_baud_end;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Pop/push decisions; a pop on the same edge frees a slot for a push
  always_comb begin
    w_empty    = (count_q == '0);
    w_full     = (count_q == c_cnt_full);
    w_baud_end = (baud_q == c_baud_last);
    w_pop      = !w_empty &&
                 ((state_q == ST_IDLE) ||
                  ((state_q == ST_STOP) && w_baud_end && (byte_idx_q == 2'd3)));
    w_push     = Out_Portin && (!w_full || w_pop);
    w_drop     = Out_Portin && !w_push;
  end

  // FIFO pointers, occupancy, display latch and sticky overflow
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    port_value_d = port_value_q;
    overflow_d   = overflow_q;
    if (w_push) begin
      wr_ptr_d     = wr_ptr_q + c_ptr_one;
      port_value_d = Busout;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
    if (w_push && !w_pop) begin
      count_d = count_q + c_cnt_one;
    end else if (!w_push && w_pop) begin
      count_d = count_q - c_cnt_one;
    end
    // A drop on the same edge as a clear leaves the flag set
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Next-state logic for the serialiser; tx is precomputed for the next state
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    if (w_pop) begin
      shift_d    = fifo_mem[rd_ptr_q];
      byte_idx_d = 2'd0;
    end
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (w_pop) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          state_d   = ST_DATA;
          baud_d    = '0;
          bit_idx_d = 3'd0;
        end else begin
          baud_d = baud_q + c_baud_one;
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + c_baud_one;
        end
      end
      ST_STOP: begin
        if (w_baud_end) begin
          baud_d = '0;
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = ST_START;
          end else if (w_pop) begin
            // Next word follows immediately with no idle gap
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + c_baud_one;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[{byte_idx_d, bit_idx_d}];
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem[wr_ptr_q] <= Busout;
    end
  end

  // All control state with asynchronous clear; tx returns high immediately
  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      port_value_q <= '0;
      overflow_q   <= 1'b0;
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_idx_q    <= 3'd0;
      byte_idx_q   <= 2'd0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      port_value_q <= port_value_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
    end
  end

  assign port_value = port_value_q;
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire
